// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control and the iterative mult/div unit.
// Contents: R-type funct constants, aluOP encodings, ALU control codes,
// writeback result_sel encodings and the mult/div sequencer state encoding.
package alu_ctrl_pkg;

    // aluOP encodings from the main decoder
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;

    // R-type funct field values
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;

    // Writeback source select
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // MULT, MULTU, DIV, DIVU share the prefix 0110xx
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath, one bit per cycle, WIDTH cycles per op.
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears the counter only)
//   start             load operands and begin an operation
//   op_div            1 = divide (restoring), 0 = multiply (shift-add)
//   op_signed         1 = signed operands handled as magnitudes with sign fixup
//   src_a, src_b      dividend/multiplicand and divisor/multiplier
//   done              high in the cycle whose edge completes the last step
//   hi, lo            final results, valid while done is high
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;
    logic             is_div;
    logic             neg_main;   // negate product, or quotient
    logic             neg_rem;    // negate remainder (dividend was negative)
    logic [WIDTH-1:0] acc;        // product high half / partial remainder
    logic [WIDTH-1:0] quo;        // multiplier being consumed / quotient being built
    logic [WIDTH-1:0] opnd;       // multiplicand / divisor magnitude

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
        if (en && v[WIDTH-1]) return -v;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                  input logic en);
        return en ? -v : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(WIDTH);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Datapath registers carry no reset; they are reloaded on every start.
    always_ff @(posedge clk) begin
        if (start) begin
            is_div <= op_div;
            acc    <= '0;
            if (op_div) begin
                quo      <= abs_val(src_a, op_signed);
                opnd     <= abs_val(src_b, op_signed);
                // Divide-by-zero keeps the all-ones quotient unsigned.
                neg_main <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]) && (src_b != '0);
                neg_rem  <= op_signed && src_a[WIDTH-1];
            end else begin
                quo      <= abs_val(src_b, op_signed);
                opnd     <= abs_val(src_a, op_signed);
                neg_main <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_rem  <= 1'b0;
            end
        end else if (count != '0) begin
            acc <= acc_nxt;
            quo <= quo_nxt;
        end
    end

    // One iteration step
    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_nxt = div_diff[WIDTH-1:0];
                quo_nxt = {quo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = div_shift[WIDTH-1:0];
                quo_nxt = {quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = mul_sum[WIDTH:1];
            quo_nxt = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    // Final result is the last step's output with sign fixup applied
    always_comb begin
        prod_fix = neg_2w({acc_nxt, quo_nxt}, neg_main);
        if (is_div) begin
            hi = neg_w(acc_nxt, neg_rem);
            lo = neg_w(quo_nxt, neg_main);
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control with mult/div sequencing and HI/LO registers.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   valid           EX-stage instruction valid
//   aluOP           00 add, 01 sub, 10 R-type, 11 reserved
//   func_field      R-type funct
//   src_a, src_b    rs / rt operands
//   control_input   ALU control code (combinational)
//   result_sel      writeback select: 00 ALU, 01 HI, 10 LO
//   illegal         unknown funct or reserved aluOP, qualified by valid
//   stall           pipeline hold while a mult/div runs
//   busy            sequencer not idle
//   hi, lo          HI/LO registers
module alu_control_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [1:0]        aluOP,
    input  logic [5:0]        func_field,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    output logic [CTRL_W-1:0] control_input,
    output logic [1:0]        result_sel,
    output logic              illegal,
    output logic              stall,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);
    md_state_t        state;
    logic [3:0]       alu_code;
    logic             known;
    logic             rtype;
    logic             start;
    logic             mt_hi;
    logic             mt_lo;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    always_comb begin
        alu_code = ALU_ADD;
        known    = 1'b1;
        unique case (aluOP)
            AOP_ADD: alu_code = ALU_ADD;
            AOP_SUB: alu_code = ALU_SUB;
            AOP_RTYPE: begin
                case (func_field)
                    F_ADD, F_ADDU:  alu_code = ALU_ADD;
                    F_SUB, F_SUBU:  alu_code = ALU_SUB;
                    F_AND:          alu_code = ALU_AND;
                    F_OR:           alu_code = ALU_OR;
                    F_NOR:          alu_code = ALU_NOR;
                    F_XOR:          alu_code = ALU_XOR;
                    F_SLT:          alu_code = ALU_SLT;
                    F_SLTU:         alu_code = ALU_SLTU;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: alu_code = ALU_ADD;
                    default:        known = 1'b0;
                endcase
            end
            default: known = 1'b0;
        endcase
    end

    assign rtype         = (aluOP == AOP_RTYPE);
    assign control_input = CTRL_W'(alu_code);
    assign illegal       = valid && !known;
    assign result_sel    = !rtype                ? SEL_ALU :
                           (func_field == F_MFHI) ? SEL_HI  :
                           (func_field == F_MFLO) ? SEL_LO  : SEL_ALU;

    // Starts and HI/LO moves are only honoured in IDLE; DONE deliberately
    // ignores the still-present stalled instruction so it retires once.
    assign start = valid && rtype && is_muldiv(func_field) && (state == ST_IDLE);
    assign mt_hi = valid && rtype && (func_field == F_MTHI) && (state == ST_IDLE);
    assign mt_lo = valid && rtype && (func_field == F_MTLO) && (state == ST_IDLE);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_div    (func_field[1]),
        .op_signed (!func_field[0]),
        .src_a     (src_a),
        .src_b     (src_b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_BUSY;
                    end else if (mt_hi) begin
                        hi <= src_a;
                    end else if (mt_lo) begin
                        lo <= src_a;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        hi    <= md_hi;
                        lo    <= md_lo;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stall covers the start cycle combinationally plus every BUSY cycle.
    assign stall = start || (state == ST_BUSY);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_control_muldiv.sv
module tb_alu_control_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  aluOP;
    logic [5:0]  func_field;
    logic [31:0] src_a, src_b;
    logic [3:0]  control_input;
    logic [1:0]  result_sel;
    logic        illegal, stall, busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
    localparam logic [5:0] DIV  = 6'b011010, DIVU  = 6'b011011;

    localparam logic [5:0] KF [18] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
        6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011, 6'b100110,
        6'b011000, 6'b011001, 6'b011010, 6'b011011,
        6'b010000, 6'b010001, 6'b010010, 6'b010011};
    localparam logic [3:0] KC [18] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110,
        4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1000, 4'b1101,
        4'b0010, 4'b0010, 4'b0010, 4'b0010,
        4'b0010, 4'b0010, 4'b0010, 4'b0010};
    localparam logic [1:0] KS [18] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
        2'b01, 2'b00, 2'b10, 2'b00};

    alu_control_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid         (valid),
        .aluOP         (aluOP),
        .func_field    (func_field),
        .src_a         (src_a),
        .src_b         (src_b),
        .control_input (control_input),
        .result_sel    (result_sel),
        .illegal       (illegal),
        .stall         (stall),
        .busy          (busy),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, MIPS HI/LO semantics
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            MULT:  p = 64'(sa * sb);
            MULTU: p = ua * ub;
            DIV, DIVU: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (f == DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[31:0], uq[31:0]};
                end
            end
            default: p = '0;
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    function automatic bit is_known(input logic [5:0] f);
        for (int i = 0; i < 18; i++) if (KF[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1; aluOP = 2'b10; func_field = f; src_a = a; src_b = b;
    endtask

    // Counts stall cycles from the start cycle; returns inside the first
    // cycle with stall low (the DONE cycle), or after a 100-cycle bound.
    task automatic wait_done(input bit hold, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
            if (!hold) valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0; aluOP = 2'b00; func_field = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state stall=%b busy=%b hi=%h lo=%h required 0 0 0 0", stall, busy, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_decode;
        logic [5:0] f;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            valid = 1'b1; aluOP = 2'b10; func_field = KF[i];
            #1;
            checks++;
            if (control_input !== KC[i] || illegal !== 1'b0 || result_sel !== KS[i]) begin
                errors++;
                $display("FAIL decode funct=%b code=%b illegal=%b sel=%b required %b 0 %b",
                         KF[i], control_input, illegal, result_sel, KC[i], KS[i]);
            end
            valid = 1'b0;   // drop before the edge so no op or move is accepted
            #1;
        end
        for (int i = 0; i < 9; i++) begin
            if (i == 0) f = 6'b000000;
            else begin
                f = 6'($urandom_range(0, 63));
                while (is_known(f)) f = 6'($urandom_range(0, 63));
            end
            valid = 1'b1; aluOP = 2'b10; func_field = f;
            #1;
            checks++;
            if (control_input !== 4'b0010 || illegal !== 1'b1 || result_sel !== 2'b00) begin
                errors++;
                $display("FAIL decode_unknown funct=%b code=%b illegal=%b sel=%b required 0010 1 00",
                         f, control_input, illegal, result_sel);
            end
            valid = 1'b0;
            #1;
            checks++;
            if (illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_unqualified funct=%b illegal=%b required 0", f, illegal);
            end
        end
        valid = 1'b1; aluOP = 2'b00; func_field = 6'b010000; #1;
        checks++;
        if (control_input !== 4'b0010 || illegal !== 1'b0 || result_sel !== 2'b00) begin
            errors++;
            $display("FAIL decode_aluop00 code=%b illegal=%b sel=%b required 0010 0 00", control_input, illegal, result_sel);
        end
        aluOP = 2'b01; #1;
        checks++;
        if (control_input !== 4'b0110 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL decode_aluop01 code=%b illegal=%b required 0110 0", control_input, illegal);
        end
        aluOP = 2'b11; func_field = 6'b100000; #1;
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL decode_aluop11 illegal=%b required 1", illegal);
        end
        valid = 1'b0;
    endtask

    task automatic test_mul;
        logic [5:0] f;
        logic [31:0] a, b, eh, el;
        int n;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin f = MULT;  a = 32'hFFFF_FFFE; b = 32'd3; eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFA; end
            else if (i == 1) begin f = MULTU; a = 32'hFFFF_FFFE; b = 32'd3; eh = 32'h0000_0002; el = 32'hFFFF_FFFA; end
            else begin
                f = ($urandom_range(0, 1) == 0) ? MULT : MULTU;
                a = $urandom; b = $urandom;
                model(f, a, b, eh, el);
            end
            issue(f, a, b);
            wait_done(1'b0, n);
            checks++;
            if (n !== 33 || hi !== eh || lo !== el || busy !== 1'b1) begin
                errors++;
                $display("FAIL mul f=%b a=%h b=%h stall=%0d hi=%h lo=%h busy=%b required 33 %h %h 1",
                         f, a, b, n, hi, lo, busy, eh, el);
            end
        end
    endtask

    task automatic test_div;
        logic [5:0] f;
        logic [31:0] a, b, eh, el;
        int n;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin f = DIV;  a = 32'hFFFF_FFF9; b = 32'd2; eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD; end
                1: begin f = DIVU; a = 32'd7; b = 32'd2; eh = 32'd1; el = 32'd3; end
                2: begin f = DIV;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; eh = 32'd0; el = 32'h8000_0000; end
                3: begin f = DIVU; a = 32'd5; b = 32'd0; eh = 32'd5; el = 32'hFFFF_FFFF; end
                4: begin f = DIV;  a = $urandom | 32'h8000_0000; b = 32'd0; model(f, a, b, eh, el); end
                default: begin
                    f = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
                    a = $urandom;
                    b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
                    if ($urandom_range(0, 1) == 1) b = -b;
                    model(f, a, b, eh, el);
                end
            endcase
            issue(f, a, b);
            wait_done(1'b0, n);
            checks++;
            if (n !== 33 || hi !== eh || lo !== el) begin
                errors++;
                $display("FAIL div f=%b a=%h b=%h stall=%0d hi=%h lo=%h required 33 %h %h",
                         f, a, b, n, hi, lo, eh, el);
            end
        end
    endtask

    task automatic test_mt_mf;
        issue(6'b010001, 32'h0000_1234, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall stall=%b required 0", stall);
        end
        @(negedge clk);
        func_field = 6'b010000; #1;
        checks++;
        if (result_sel !== 2'b01 || hi !== 32'h0000_1234 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mfhi sel=%b hi=%h stall=%b required 01 00001234 0", result_sel, hi, stall);
        end
        func_field = 6'b010011; src_a = 32'hCAFE_0001;
        @(negedge clk);
        func_field = 6'b010010; #1;
        checks++;
        if (result_sel !== 2'b10 || lo !== 32'hCAFE_0001 || hi !== 32'h0000_1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mflo sel=%b lo=%h hi=%h busy=%b required 10 cafe0001 00001234 0", result_sel, lo, hi, busy);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_midop;
        logic [31:0] a, b, eh, el;
        int n;
        issue(MULT, $urandom, $urandom);
        @(negedge clk); valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop stall=%b busy=%b hi=%h lo=%h required 0 0 0 0", stall, busy, hi, lo);
        end
        a = $urandom; b = $urandom;
        model(MULT, a, b, eh, el);
        valid = 1'b1; aluOP = 2'b10; func_field = MULT; src_a = a; src_b = b;
        wait_done(1'b0, n);
        checks++;
        if (n !== 33 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL mult_after_reset stall=%0d hi=%h lo=%h required 33 %h %h", n, hi, lo, eh, el);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, eh, el;
        int n;
        a = $urandom; b = $urandom;
        model(MULT, a, b, eh, el);
        issue(MULT, a, b);
        wait_done(1'b1, n);
        checks++;
        if (n !== 33 || hi !== eh || lo !== el || valid !== 1'b1) begin
            errors++;
            $display("FAIL mult_held stall=%0d hi=%h lo=%h required 33 %h %h", n, hi, lo, eh, el);
        end
        a = $urandom; b = 32'($urandom_range(1, 1000));
        issue(DIV, a, b);
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL no_restart busy=%b stall=%b required 0 1", busy, stall);
        end
        model(DIV, a, b, eh, el);
        wait_done(1'b0, n);
        checks++;
        if (n !== 33 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL div_b2b stall=%0d hi=%h lo=%h required 33 %h %h", n, hi, lo, eh, el);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_after busy=%b stall=%b required 0 0", busy, stall);
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_mul;
        test_div;
        test_mt_mf;
        test_reset_midop;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
